// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU; one operation in flight, registered result.
// Define ALU_ARBITER_ROUND_ROBIN_EN for round-robin arbitration (fixed priority to port 0 otherwise).

module alu_core #(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [3:0]           op,
    output logic [WORD_SIZE-1:0] result
);
    localparam int SHW = $clog2(WORD_SIZE);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op[2:0])
            3'd0: result = op[3] ? (a - b) : (a + b);
            3'd1: result = a << shamt;
            3'd2: result = {{(WORD_SIZE-1){1'b0}}, ($signed(a) < $signed(b))};
            3'd3: result = {{(WORD_SIZE-1){1'b0}}, (a < b)};
            3'd4: result = a ^ b;
            3'd5: begin
                // Kept out of a ternary so the signed context of >>> is not lost.
                if (op[3]) result = $unsigned($signed(a) >>> shamt);
                else       result = a >> shamt;
            end
            3'd6: result = a | b;
            3'd7: result = a & b;
            default: result = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic [3:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    input  logic [3:0]           req1_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic                 busy,
    output logic [1:0]           fsm_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid/operands until ready; the owner holds rsp ready as it likes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WORD_SIZE-1:0] a_q;
    logic [WORD_SIZE-1:0] b_q;
    logic [3:0]           op_q;
    logic                 owner_q;
    logic [WORD_SIZE-1:0] result_q;
    logic [WORD_SIZE-1:0] alu_out;
    logic                 grant;
    logic                 take;
    logic                 owner_ready;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    logic last_grant;
`endif

    alu_core #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_out)
    );

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Request acceptance depends only on state, never on response-side inputs.
    assign take        = (state == IDLE) && (req0_valid || req1_valid) && !reset;
    assign req0_ready  = take && !grant;
    assign req1_ready  = take && grant;
    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (owner_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            owner_q  <= 1'b0;
            result_q <= '0;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (take) begin
                a_q     <= grant ? req1_a  : req0_a;
                b_q     <= grant ? req1_b  : req0_b;
                op_q    <= grant ? req1_op : req0_op;
                owner_q <= grant;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
                last_grant <= grant;
`endif
            end
            if (state == EXEC) result_q <= alu_out;
        end
    end

    assign rsp0_valid = (state == RESP) && !owner_q && !reset;
    assign rsp1_valid = (state == RESP) && owner_q && !reset;
    assign rsp_result = result_q;
    assign busy       = (state != IDLE) && !reset;
    assign fsm_state  = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: randomized requests against a queue-based reference model.
// Honours ALU_ARBITER_ROUND_ROBIN_EN to predict the grant order of the matching build.

module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_a [2];
    logic [31:0] req_b [2];
    logic [3:0]  req_op [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_result;
    logic        busy;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    logic [31:0] ba [2][4];
    logic [31:0] bb [2][4];
    logic [3:0]  bop [2][4];
    int          bn [2];
    int          model_last = 1;
    logic        rand_ready_en = 1'b0;
    logic        stalled [2];
    logic [31:0] held [2];

    always #5 clk = ~clk;

    alu_arbiter #(.WORD_SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req_valid[0]),
        .req0_ready (req_ready[0]),
        .req0_a     (req_a[0]),
        .req0_b     (req_b[0]),
        .req0_op    (req_op[0]),
        .req1_valid (req_valid[1]),
        .req1_ready (req_ready[1]),
        .req1_a     (req_a[1]),
        .req1_b     (req_b[1]),
        .req1_op    (req_op[1]),
        .rsp0_valid (rsp_valid[0]),
        .rsp0_ready (rsp_ready[0]),
        .rsp1_valid (rsp_valid[1]),
        .rsp1_ready (rsp_ready[1]),
        .rsp_result (rsp_result),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic signed [31:0] sa;
        int unsigned        sh;
        sh = b[4:0];
        sa = a;
        case (op[2:0])
            3'd0: return op[3] ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (op[3]) begin
                    sa = sa >>> sh;
                    return sa;
                end
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int pick_winner(input bool_both, input int pending_port);
        if (bool_both) begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
            return 1 - model_last;
`else
            return 0;
`endif
        end
        return pending_port;
    endfunction

    task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op);
        int n;
        req_valid[p] = 1'b1;
        req_a[p]     = a;
        req_b[p]     = b;
        req_op[p]    = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[p] && n < 300);
        if (!req_ready[p]) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: port %0d got ready=0 expected ready=1", p);
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    // Model the grant sequence from the pending ops, push expectations, then drive both ports.
    task automatic run_batch();
        int k [2];
        int w;
        k[0] = 0;
        k[1] = 0;
        while (k[0] < bn[0] || k[1] < bn[1]) begin
            w = pick_winner((k[0] < bn[0]) && (k[1] < bn[1]), (k[0] < bn[0]) ? 0 : 1);
            model_last = w;
            exp_q.push_back({w[0], ref_alu(ba[w][k[w]], bb[w][k[w]], bop[w][k[w]])});
            k[w]++;
        end
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < bn[0]; i++) drive_req(0, ba[0][i], bb[0][i], bop[0][i]);
            end
            begin
                for (int i = 0; i < bn[1]; i++) drive_req(1, ba[1][i], bb[1][i], bop[1][i]);
            end
        join
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fsm_state != 2'd0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops on each response handshake and checks that stalled results hold.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset) begin
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end else begin
            if (rsp_valid[0] && rsp_valid[1]) check("rsp_both_valid", 64'd1, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p]) begin
                    if (stalled[p]) check("rsp_hold", 64'(rsp_result), 64'(held[p]));
                    if (rsp_ready[p]) begin
                        stalled[p] = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", 64'(p), 64'd99);
                        end else begin
                            e = exp_q.pop_front();
                            check("rsp_port", 64'(p), 64'(e[32]));
                            check("rsp_result", 64'(rsp_result), 64'(e[31:0]));
                        end
                    end else begin
                        stalled[p] = 1'b1;
                        held[p]    = rsp_result;
                    end
                end else begin
                    stalled[p] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            rsp_ready[0] = ($urandom_range(0, 3) != 0);
            rsp_ready[1] = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 1'b0;
            req_a[p]     = '0;
            req_b[p]     = '0;
            req_op[p]    = '0;
            rsp_ready[p] = 1'b1;
            stalled[p]   = 1'b0;
            held[p]      = '0;
        end

        // Reset with a pending request: nothing may be accepted.
        req_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req0_ready", 64'(req_ready[0]), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_valid", 64'({rsp_valid[0], rsp_valid[1]}), 64'd0);
        check("reset_result", 64'(rsp_result), 64'd0);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready", 64'({req_ready[0], req_ready[1]}), 64'd0);
        check("idle_state", 64'(fsm_state), 64'd0);

        // ADD timing on port 0: handshake N, EXEC N+1, response N+2, idle N+3.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_a[0] = 32'd5;
        req_b[0] = 32'd7;
        req_op[0] = 4'd0;
        exp_q.push_back({1'b0, 32'd12});
        model_last = 0;
        @(negedge clk);
        check("add_n_ready0", 64'(req_ready[0]), 64'd1);
        check("add_n_ready1", 64'(req_ready[1]), 64'd0);
        check("add_n_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("add_n1_busy", 64'(busy), 64'd1);
        check("add_n1_rsp0", 64'(rsp_valid[0]), 64'd0);
        check("add_n1_state", 64'(fsm_state), 64'd1);
        @(negedge clk);
        check("add_n2_rsp0", 64'(rsp_valid[0]), 64'd1);
        check("add_n2_result", 64'(rsp_result), 64'd12);
        check("add_n2_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("add_n3_busy", 64'(busy), 64'd0);

        // Subtract on port 1.
        bn[0] = 0;
        bn[1] = 1;
        ba[1][0] = 32'd5;
        bb[1][0] = 32'd7;
        bop[1][0] = 4'd8;
        run_batch();
        drain();

        // Contention with both ports valid back to back.
        bn[0] = 2;
        bn[1] = 2;
        ba[0][0] = 32'hFFFF_FFFF; bb[0][0] = 32'd1; bop[0][0] = 4'd2;
        ba[1][0] = 32'hFFFF_FFFF; bb[1][0] = 32'd1; bop[1][0] = 4'd3;
        ba[0][1] = 32'h8000_0000; bb[0][1] = 32'd4; bop[0][1] = 4'd13;
        ba[1][1] = 32'h0000_00F0; bb[1][1] = 32'h0F; bop[1][1] = 4'd6;
        run_batch();
        drain();

        // Back-pressure on port 0 while port 1 waits.
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_a[0] = 32'hF0;
        req_b[0] = 32'h0F;
        req_op[0] = 4'd6;
        exp_q.push_back({1'b0, 32'hFF});
        model_last = 0;
        @(negedge clk);
        check("bp_ready0", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_a[1] = 32'd3;
        req_b[1] = 32'd4;
        req_op[1] = 4'd1;
        exp_q.push_back({1'b1, 32'd48});
        @(negedge clk);
        check("bp_exec_ready1", 64'(req_ready[1]), 64'd0);
        repeat (5) begin
            @(negedge clk);
            check("bp_rsp0_valid", 64'(rsp_valid[0]), 64'd1);
            check("bp_result", 64'(rsp_result), 64'hFF);
            check("bp_ready1", 64'(req_ready[1]), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_ready1", 64'(req_ready[1]), 64'd0);
        @(negedge clk);
        check("bp_idle_ready1", 64'(req_ready[1]), 64'd1);
        model_last = 1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();

        // Reset during EXEC discards the operation.
        @(posedge clk);
        #1;
        req_valid[0] = 1'b1;
        req_a[0] = 32'd1;
        req_b[0] = 32'd2;
        req_op[0] = 4'd4;
        @(negedge clk);
        check("rst_exec_hs", 64'(req_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = 1;
        @(negedge clk);
        check("rst_exec_state", 64'(fsm_state), 64'd0);
        check("rst_exec_busy", 64'(busy), 64'd0);
        repeat (4) begin
            @(negedge clk);
            check("rst_exec_no_rsp", 64'({rsp_valid[0], rsp_valid[1]}), 64'd0);
        end
        bn[0] = 1;
        bn[1] = 0;
        ba[0][0] = 32'hF0F0;
        bb[0][0] = 32'hFFFF;
        bop[0][0] = 4'd4;
        run_batch();
        drain();

        // Random batches with random response back-pressure.
        rand_ready_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++) begin
                bn[p] = mask[p] ? $urandom_range(1, 3) : 0;
                for (int i = 0; i < 4; i++) begin
                    ba[p][i]  = rand_word();
                    bb[p][i]  = rand_word();
                    bop[p][i] = 4'($urandom_range(0, 15));
                end
            end
            run_batch();
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, e.g. the execute stage (port 0) and the address/branch-compare unit (port 1). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates, latches the operands, evaluates the ALU for one cycle, then holds the registered result until the owner accepts it. Only one operation is in flight at a time.

## Interface
- WORD_SIZE, 32, operand and result width; passed through to the ALU instance.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WORD_SIZE  operands.
- req0_op / req1_op  in  4  ALU operation code.
  - Bits [2:0]: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7.
  - Bit 3 selects subtract (with ADD) or arithmetic shift (with SR).
- rsp0_valid / rsp1_valid  out  1  result available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester accepts the result.
- rsp_result  out  WORD_SIZE  shared result bus; meaningful only while the owner's rsp*_valid is high.
- busy  out  1  high in every state except IDLE.

## Operation
States: IDLE, EXEC, RESP.

IDLE
- If any req*_valid is high, select one winner by the arbitration rule.
- Drive the winner's req*_ready high combinationally in the same cycle; the loser's ready stays low.
- On the handshake, latch a, b, op and the owner index; go to EXEC.
- If no request is valid, stay in IDLE.

EXEC
- The ALU evaluates the latched operands.
- At the clock edge, register its output into rsp_result; go to RESP.
- No req*_ready is asserted.

RESP
- Assert the owner's rsp*_valid; hold rsp_result stable.
- Go to IDLE on the cycle the owner's rsp*_ready is high.
- The other port's rsp_ready is ignored.
- No new request is accepted in the RESP cycle, including the cycle the response handshake completes.

Operand, owner and result registers do not change outside their load cycles.

Arbitration
- Round-robin with the macro enabled; fixed priority with it disabled (see Configuration).
- last_grant resets to 1, so port 0 wins the first contention.
- A requester must keep its valid, operands and op stable until ready. The block does not check this.

Reset
- All outputs are 0: ready, rsp_valid, rsp_result and busy.
- State returns to IDLE and last_grant to 1.
- Reset mid-operation (EXEC or RESP) discards the transaction; no response is issued.

## Timing
- Request handshake in cycle N.
- EXEC in cycle N+1.
- rsp*_valid and rsp_result valid from cycle N+2.
- If rsp_ready is high at N+2, the block is back in IDLE at N+3, and the next request can handshake at N+3.
- Minimum 3 cycles per operation; response back-pressure extends RESP indefinitely.
- ALU path: one combinational evaluation in EXEC; the result is registered.
- No path from rsp*_ready to req*_ready in the same cycle.

## Configuration
- Macro: ALU_ARBITER_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant the port not equal to last_grant. Update last_grant on every grant.
- Undefined: port 0 always wins contention; last_grant is not implemented.
- With only one port requesting, both builds grant that port.

## Test plan
- Reset, then idle: all outputs 0 and busy 0.
- Single request, ADD: req0 a=5, b=7, op=0 -> handshake at N, rsp0_valid at N+2 with rsp_result=12, busy high N+1..N+2.
- Subtract: req1 a=5, b=7, op=8 -> rsp1_valid, rsp_result=0xFFFFFFFE; rsp0_valid stays 0.
- Contention, round-robin build, both ports held valid continuously:
  - grant order is 0,1,0,1;
  - SLT op=2 a=0xFFFFFFFF, b=1 returns 1;
  - SLTU op=3 with the same operands returns 0.
  - Fixed-priority build: port 0 is granted every time.
- Back-pressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and rsp_result stable, req1_ready stays 0; release -> IDLE the next cycle, then req1 is granted.
- Reset asserted in EXEC -> next cycle IDLE, no rsp*_valid ever; a subsequent XOR 0xF0F0 ^ 0xFFFF returns 0x0F0F.
